// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter/multiplexer.
//   bus_state_t : arbiter FSM states (IDLE, OWNED)
//   idx_w(n)    : index width for n items, never below 1
//   popcount(v) : number of set bits; callers zero-extend to POP_MAX_W
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } bus_state_t;

  // Upper bound on request-vector width accepted by popcount.
  localparam int unsigned POP_MAX_W = 256;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bus_prio_pick.sv
// Combinational winner search shared by fixed-priority and round-robin modes
// of bus_arbiter_mux. Scans descending from start, wrapping from 0 to
// N_SRC-1; the first requester not masked by exclude wins.
// Ports:
//   req     in   N_SRC  request vector
//   exclude in   N_SRC  sources barred from winning this cycle
//   start   in   IW     first index examined
//   found   out  1      a winner exists
//   winner  out  IW     winning index (0 when !found)
module bus_prio_pick
  import bus_pkg::*;
#(
  parameter int unsigned N_SRC = 24,
  parameter int unsigned IW    = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] exclude,
  input  logic [IW-1:0]    start,
  output logic             found,
  output logic [IW-1:0]    winner
);

  always_comb begin : search
    int unsigned s;
    int unsigned pos;
    found  = 1'b0;
    winner = '0;
    s      = 32'(start);
    pos    = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      pos = (s >= k) ? (s - k) : (s + N_SRC - k);
      if (!found && req[pos] && !exclude[pos]) begin
        found  = 1'b1;
        winner = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered, arbitrated bus multiplexer: N_SRC sources request the shared
// bus, one owner is granted, and the owner's data is registered onto bus_out.
// Ownership is held while the owner keeps requesting, bounded by MAX_HOLD
// cycles when others wait (0 = unlimited). Counts contended cycles.
// Optional macro BUS_RR_ARB_EN selects round-robin arbitration; otherwise
// the highest requesting index wins.
// Ports:
//   clock           in   rising-edge clock
//   clear           in   synchronous active-high reset
//   req             in   per-source request
//   data_in         in   flattened source data, source i at [i*DATA_W +: DATA_W]
//   bus_out         out  registered bus value (0 when idle)
//   grant           out  registered one-hot owner (0 when idle)
//   busy            out  grant != 0
//   preempt         out  one-cycle pulse when the previous owner was forced off
//   contention_cnt  out  saturating count of cycles with two or more requests
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int unsigned N_SRC    = 24,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]       bus_out,
  output logic [N_SRC-1:0]        grant,
  output logic                    busy,
  output logic                    preempt,
  output logic [CNT_W-1:0]        contention_cnt
);

  localparam int unsigned IW = idx_w(N_SRC);
  localparam int unsigned HW = idx_w(MAX_HOLD + 1);
  // The hold counter stops at MAX_HOLD so an owner that ran alone past the
  // limit is still preempted as soon as another source starts waiting.
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD != 0) ? HW'(MAX_HOLD) : '1;

  bus_state_t        state, state_n;
  logic [IW-1:0]     owner, owner_n, start, win, sel;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [N_SRC-1:0]  owner_mask, exclude, grant_n;
  logic              owner_req, others, do_preempt, found, take_win, keep, preempt_n;
  logic [DATA_W-1:0] bus_n;
  logic [CNT_W-1:0]  cnt_n;

  bus_prio_pick #(
    .N_SRC (N_SRC),
    .IW    (IW)
  ) u_pick (
    .req     (req),
    .exclude (exclude),
    .start   (start),
    .found   (found),
    .winner  (win)
  );

  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    owner_req  = |(req & owner_mask);
    others     = |(req & ~owner_mask);
    do_preempt = (state == OWNED) && (MAX_HOLD != 0) && owner_req &&
                 (hold_cnt == HOLD_SAT) && others;
    exclude    = do_preempt ? owner_mask : '0;
`ifdef BUS_RR_ARB_EN
    // owner doubles as last_owner; after reset (0) the search starts at N_SRC-1.
    start = (owner == '0) ? IW'(N_SRC - 1) : owner - 1'b1;
`else
    start = IW'(N_SRC - 1);
`endif
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    hold_n    = hold_cnt;
    grant_n   = '0;
    bus_n     = '0;
    preempt_n = do_preempt;
    take_win  = 1'b0;
    keep      = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) take_win = 1'b1;
      end
      OWNED: begin
        if (owner_req && !do_preempt) keep = 1'b1;
        else if (found)               take_win = 1'b1;
        else                          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    sel = take_win ? win : owner;
    if (take_win) begin
      state_n = OWNED;
      owner_n = win;
      hold_n  = HW'(1);
    end else if (keep && hold_cnt != HOLD_SAT) begin
      hold_n = hold_cnt + 1'b1;
    end
    if (take_win || keep) begin
      grant_n[sel] = 1'b1;
      bus_n        = data_in[sel*DATA_W +: DATA_W];
    end

    cnt_n = contention_cnt;
    if (popcount(POP_MAX_W'(req)) >= 2 && contention_cnt != '1)
      cnt_n = contention_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state          <= IDLE;
      owner          <= '0;
      hold_cnt       <= '0;
      grant          <= '0;
      bus_out        <= '0;
      preempt        <= 1'b0;
      contention_cnt <= '0;
    end else begin
      state          <= state_n;
      owner          <= owner_n;
      hold_cnt       <= hold_n;
      grant          <= grant_n;
      bus_out        <= bus_n;
      preempt        <= preempt_n;
      contention_cnt <= cnt_n;
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench for bus_arbiter_mux. Two instances share inputs:
// dut_a uses default parameters, dut_b uses MAX_HOLD=1 and CNT_W=4 for
// rapid preemption and counter saturation. A behavioural model tracks each.
module tb_bus_arbiter_mux;

  localparam int N = 24;
  localparam int W = 32;

  logic            clock = 1'b0;
  logic            clear;
  logic [N-1:0]    req;
  logic [N*W-1:0]  data_in;

  logic [W-1:0]    a_bus, b_bus;
  logic [N-1:0]    a_grant, b_grant;
  logic            a_busy, b_busy, a_pre, b_pre;
  logic [15:0]     a_cnt;
  logic [3:0]      b_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         owner;  // -1 when idle
    int         last;
    int         hold;
    logic [31:0] bus;
    logic       pre;
    int         cnt;
  } mstate_t;

  mstate_t ma, mb;

  always #5 clock = ~clock;

  bus_arbiter_mux #(.N_SRC(N), .DATA_W(W), .MAX_HOLD(8), .CNT_W(16)) dut_a (
    .clock(clock), .clear(clear), .req(req), .data_in(data_in),
    .bus_out(a_bus), .grant(a_grant), .busy(a_busy), .preempt(a_pre),
    .contention_cnt(a_cnt)
  );

  bus_arbiter_mux #(.N_SRC(N), .DATA_W(W), .MAX_HOLD(1), .CNT_W(4)) dut_b (
    .clock(clock), .clear(clear), .req(req), .data_in(data_in),
    .bus_out(b_bus), .grant(b_grant), .busy(b_busy), .preempt(b_pre),
    .contention_cnt(b_cnt)
  );

  function automatic int pick(input logic [N-1:0] r, input int last, input int excl);
`ifdef BUS_RR_ARB_EN
    for (int dd = 1; dd <= N; dd++) begin
      int i;
      i = ((last - dd) % N + N) % N;
      if (r[i] && i != excl) return i;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i] && i != excl) return i;
    end
`endif
    return -1;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input logic clr, input logic [N-1:0] r,
                                    input logic [N*W-1:0] d, input int max_hold, input int cnt_max);
    mstate_t ns;
    int n, w;
    ns = s;
    if (clr) begin
      ns = '{owner: -1, last: 0, hold: 0, bus: '0, pre: 1'b0, cnt: 0};
      return ns;
    end
    n = $countones(r);
    ns.pre = 1'b0;
    if (n >= 2 && s.cnt < cnt_max) ns.cnt = s.cnt + 1;
    if (s.owner >= 0 && r[s.owner]) begin
      if (max_hold != 0 && s.hold >= max_hold && n >= 2) begin
        w = pick(r, s.last, s.owner);
        ns.pre = 1'b1;
      end else begin
        ns.hold = (max_hold != 0 && s.hold >= max_hold) ? max_hold : s.hold + 1;
        ns.bus  = d[s.owner*W +: W];
        return ns;
      end
    end else begin
      w = pick(r, s.last, -1);
    end
    if (w < 0) begin
      ns.owner = -1;
      ns.bus   = '0;
    end else begin
      ns.owner = w;
      ns.last  = w;
      ns.hold  = 1;
      ns.bus   = d[w*W +: W];
    end
    return ns;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input mstate_t m, input logic [31:0] bus,
                         input logic [N-1:0] g, input logic bz, input logic p, input logic [15:0] c);
    logic [N-1:0] ge;
    ge = (m.owner < 0) ? '0 : (N'(1) << m.owner);
    chk({tag, ".grant"},   32'(g),  32'(ge));
    chk({tag, ".bus"},     bus,     m.bus);
    chk({tag, ".busy"},    32'(bz), 32'(m.owner >= 0));
    chk({tag, ".preempt"}, 32'(p),  32'(m.pre));
    chk({tag, ".cnt"},     32'(c),  32'(m.cnt));
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    ma = mstep(ma, clear, req, data_in, 8, 16'hFFFF);
    mb = mstep(mb, clear, req, data_in, 1, 15);
    #1;
    cmp_dut({tag, ".a"}, ma, a_bus, a_grant, a_busy, a_pre, a_cnt);
    cmp_dut({tag, ".b"}, mb, b_bus, b_grant, b_busy, b_pre, {12'b0, b_cnt});
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom();
  endtask

  initial begin
    int exp5[5];
    int pre_owner;

    clear   = 1'b1;
    req     = '0;
    data_in = '0;
    ma = mstep(ma, 1'b1, req, data_in, 8, 16'hFFFF);
    mb = mstep(mb, 1'b1, req, data_in, 1, 15);
    randomize_data();

    // Reset, then idle with no requests.
    cycle("reset");
    cycle("reset");
    clear = 1'b0;
    repeat (3) cycle("idle");
    chk("idle_grant", 32'(a_grant), 32'h0);
    chk("idle_cnt",   32'(a_cnt),   32'h0);

    // Single requester, one-cycle latency.
    data_in[5*W +: W] = 32'hDEAD_BEEF;
    req = N'(1) << 5;
    cycle("single");
    chk("single_grant", 32'(a_grant), 32'h20);
    chk("single_bus",   a_bus,        32'hDEAD_BEEF);
    chk("single_busy",  32'(a_busy),  32'h1);

    // Two requesters; then owner drops and the other takes over without a bubble.
    req = (N'(1) << 2) | (N'(1) << 20);
    cycle("contend");
`ifdef BUS_RR_ARB_EN
    chk("contend_grant", 32'(a_grant), 32'h4);
`else
    chk("contend_grant", 32'(a_grant), 32'h10_0000);
`endif
    chk("contend_cnt", 32'(a_cnt), 32'h1);
    req = N'(1) << 2;
    cycle("handoff");
    chk("handoff_grant", 32'(a_grant), 32'h4);

    // Bounded tenure: after eight owned cycles the waiter is granted with a preempt pulse.
    req = '0;
    cycle("gap");
    req = (N'(1) << 3) | (N'(1) << 1);
    pre_owner = -1;
    for (int c = 1; c <= 9; c++) cycle("tenure");
`ifdef BUS_RR_ARB_EN
    chk("tenure_grant", 32'(a_grant), 32'h8);
`else
    chk("tenure_grant", 32'(a_grant), 32'h2);
`endif
    chk("tenure_preempt", 32'(a_pre), 32'h1);
    cycle("tenure_after");
    chk("tenure_pulse", 32'(a_pre), 32'h0);

    // Rotation with MAX_HOLD=1 on dut_b.
    req   = '0;
    clear = 1'b1;
    cycle("rr_clear");
    clear = 1'b0;
    req   = (N'(1) << 0) | (N'(1) << 4) | (N'(1) << 9);
`ifdef BUS_RR_ARB_EN
    exp5 = '{9, 4, 0, 9, 4};
`else
    exp5 = '{9, 4, 9, 4, 9};
`endif
    for (int k = 0; k < 5; k++) begin
      cycle("rot");
      chk("rot_grant", 32'(b_grant), 32'(N'(1) << exp5[k]));
    end

    // Clear mid-tenure with requests pending, then re-grant one cycle later.
    clear = 1'b1;
    cycle("mid_clear");
    chk("mid_clear_grant", 32'(a_grant), 32'h0);
    chk("mid_clear_bus",   a_bus,        32'h0);
    chk("mid_clear_cnt",   32'(a_cnt),   32'h0);
    clear = 1'b0;
    cycle("regrant");
    chk("regrant_busy", 32'(a_busy), 32'h1);

    // Saturation of the 4-bit counter.
    repeat (20) cycle("sat");
    chk("sat_cnt", 32'(b_cnt), 32'hF);
    repeat (3) cycle("sat_hold");
    chk("sat_stays", 32'(b_cnt), 32'hF);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      randomize_data();
      if ($urandom_range(0, 9) < 3)
        req = N'($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 19) == 0) req = '0;
      clear = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
